cmult_round_sat_fifo: RTL and testbench

//  Downstream stage of the complex multiplier. Takes each full-width I/Q product
//  (2*SIZE_DATA bits, one-cycle valid pulse, no backpressure) and scales it back to

---
 rtl/cmult_round_sat_fifo.sv | 198 +++++++++++++++++++
 tb/tb_cmult_round_sat_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmult_round_sat_fifo.sv
// cmult_round_sat_fifo: scales full-width complex-multiplier products back to
// SIZE_DATA bits (arithmetic shift right by SHIFT, round-half-up, saturate) and
// queues the results in a DEPTH-entry show-ahead FIFO with a valid/ready output.
// Optional feature macro: CMULT_RSF_SATCNT_EN adds the sat_count output, a
// saturating count of samples in which I or Q clipped.
module cmult_round_sat_fifo #(
    parameter int SIZE_DATA = 16,
    parameter int SHIFT     = 15,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [2*SIZE_DATA-1:0]   in_i,
    input  logic [2*SIZE_DATA-1:0]   in_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SIZE_DATA-1:0]     out_i,
    output logic [SIZE_DATA-1:0]     out_q,
    output logic                     ovf,
    output logic                     drop,
    input  logic                     clr_flags
`ifdef CMULT_RSF_SATCNT_EN
    ,
    output logic [15:0]              sat_count
`endif
);

    localparam int W  = 2 * SIZE_DATA;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Rounding constant and saturation limits, all at W+1 bits so the rounded sum never wraps.
    localparam logic signed [W:0] HALF    = (W + 1)'(1) << (SHIFT - 1);
    localparam logic signed [W:0] SAT_MAX = {{(W - SIZE_DATA + 2){1'b0}}, {(SIZE_DATA - 1){1'b1}}};
    localparam logic signed [W:0] SAT_MIN = {{(W - SIZE_DATA + 2){1'b1}}, {(SIZE_DATA - 1){1'b0}}};

    // Returns {clipped, scaled_value} for one component.
    function automatic logic [SIZE_DATA:0] round_sat(input logic signed [W-1:0] x);
        logic signed [W:0] sum;
        logic signed [W:0] sh;
        sum = $signed({x[W-1], x}) + HALF;
        sh  = sum >>> SHIFT;
        if (sh > SAT_MAX) begin
            return {1'b1, SAT_MAX[SIZE_DATA-1:0]};
        end else if (sh < SAT_MIN) begin
            return {1'b1, SAT_MIN[SIZE_DATA-1:0]};
        end else begin
            return {1'b0, sh[SIZE_DATA-1:0]};
        end
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: round/saturate register and sticky flags
    // ------------------------------------------------------------------
    logic                 s1_valid_q, s1_valid_d;
    logic [SIZE_DATA-1:0] s1_i_q, s1_i_d;
    logic [SIZE_DATA-1:0] s1_q_q, s1_q_d;
    logic                 ovf_q, ovf_d;
    logic                 drop_q, drop_d;
    logic                 sat_i, sat_q, sat_evt;

    // FIFO state
    logic [SIZE_DATA-1:0] mem_i_q [DEPTH];
    logic [SIZE_DATA-1:0] mem_q_q [DEPTH];
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 out_valid_q, out_valid_d;
    logic [SIZE_DATA-1:0] out_i_q, out_i_d;
    logic [SIZE_DATA-1:0] out_q_q, out_q_d;
    logic                 pop, full, wr_en, drop_set;
    logic [SIZE_DATA-1:0] head_i, head_q;

    // Scale both components and decide the next flag values; a same-cycle set beats clr_flags.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        s1_valid_d = in_valid;
        {sat_i, s1_i_d} = round_sat(in_i);
        {sat_q, s1_q_d} = round_sat(in_q);
        sat_evt = in_valid & (sat_i | sat_q);
        ovf_d   = sat_evt | (ovf_q & ~clr_flags);
        drop_d  = drop_set | (drop_q & ~clr_flags);
    end

    // Stage-1 pipeline register and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_i_q     <= '0;
            s1_q_q     <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            s1_valid_q <= s1_valid_d;
            s1_i_q     <= s1_i_d;
            s1_q_q     <= s1_q_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: show-ahead FIFO with registered head
    // ------------------------------------------------------------------

    // Pointer/count update, full-FIFO policy and next head value.
    always_comb begin
        pop      = out_valid_q & out_ready;
        full     = (count_q == CW'(DEPTH));
        wr_en    = s1_valid_q & (~full | pop);
        drop_set = s1_valid_q & full & ~pop;

        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;

        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // The new head is the incoming sample only when it lands in the slot the read pointer moves to.
        if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
            head_i = s1_i_q;
            head_q = s1_q_q;
        end else begin
            head_i = mem_i_q[rd_ptr_d];
            head_q = mem_q_q[rd_ptr_d];
        end

        out_valid_d = (count_d != '0);
        out_i_d     = out_valid_d ? head_i : out_i_q;
        out_q_d     = out_valid_d ? head_q : out_q_q;
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the count gates every read, so stale contents are never visible.
        if (wr_en) begin
            mem_i_q[wr_ptr_q] <= s1_i_q;
            mem_q_q[wr_ptr_q] <= s1_q_q;
        end
    end

    // FIFO control state and registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign ovf       = ovf_q;
    assign drop      = drop_q;

`ifdef CMULT_RSF_SATCNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    // Count clipped samples, sticking at all-ones; a clip in the clearing cycle counts as the first.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (clr_flags) begin
            sat_cnt_d = sat_evt ? 16'd1 : 16'd0;
        end else if (sat_evt && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    // Saturation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_cmult_round_sat_fifo.sv
// Directed bench for cmult_round_sat_fifo (SIZE_DATA=16, SHIFT=15, DEPTH=4).
// Expected samples are queued when a stimulus is driven and compared as the
// DUT hands them out; flags and handshake timing are checked inline.
module tb_cmult_round_sat_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_i, in_q;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_i, out_q;
    logic        ovf, drop;
    logic        clr_flags;
`ifdef CMULT_RSF_SATCNT_EN
    logic [15:0] sat_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] sb [$];
    logic [31:0] mon_exp;

    cmult_round_sat_fifo #(.SIZE_DATA(16), .SHIFT(15), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_i     (out_i),
        .out_q     (out_q),
        .ovf       (ovf),
        .drop      (drop),
        .clr_flags (clr_flags)
`ifdef CMULT_RSF_SATCNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; the expected result is queued only when the sample should survive.
    task automatic send(input logic [31:0] i, input logic [31:0] q,
                        input logic [15:0] ei, input logic [15:0] eq, input bit keep);
        in_valid = 1'b1;
        in_i     = i;
        in_q     = q;
        if (keep) sb.push_back({ei, eq});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag, input int max_cycles);
        for (int n = 0; n < max_cycles; n++) begin
            if (sb.size() == 0 && !out_valid) break;
            tick();
        end
        check(tag, {31'd0, (sb.size() == 0 && !out_valid)}, 32'd1);
    endtask

    // Every accepted head is checked against the oldest expected sample.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", {out_i, out_q}, 32'hxxxx_xxxx);
            end else begin
                mon_exp = sb.pop_front();
                check("pop_i", {16'd0, out_i}, {16'd0, mon_exp[31:16]});
                check("pop_q", {16'd0, out_q}, {16'd0, mon_exp[15:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_i      = '0;
        in_q      = '0;
        out_ready = 1'b0;
        clr_flags = 1'b0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_i", {16'd0, out_i}, 32'd0);
        check("rst_out_q", {16'd0, out_q}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_drop", {31'd0, drop}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: rounding and two-edge latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_i      = 32'h0000_4000;
        in_q      = 32'hFFFF_C000;
        sb.push_back({16'h0001, 16'h0000});
        tick();
        in_valid = 1'b0;
        check("lat_edge1", {31'd0, out_valid}, 32'd0);
        tick();
        check("lat_edge2", {31'd0, out_valid}, 32'd1);
        tick();
        check("t1_ovf", {31'd0, ovf}, 32'd0);
        wait_empty("t1_drain", 10);

        // 2: saturation and sticky ovf
        send(32'h4000_0000, 32'hC000_0000, 16'h7FFF, 16'h8000, 1);
        check("t2_ovf_set", {31'd0, ovf}, 32'd1);
        send(32'h0000_0000, 32'hBFFF_0000, 16'h0000, 16'h8000, 1);
        check("t2_ovf_sticky", {31'd0, ovf}, 32'd1);
        wait_empty("t2_drain", 10);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("t2_ovf_clr", {31'd0, ovf}, 32'd0);

        // 3: overflow of a stalled FIFO, then drain in order
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            send(32'(k) << 15, 32'd0, 16'(k), 16'd0, k <= 4);
        end
        tick();
        tick();
        check("t3_drop", {31'd0, drop}, 32'd1);
        check("t3_stall_valid", {31'd0, out_valid}, 32'd1);
        check("t3_stall_i0", {16'd0, out_i}, 32'd1);
        tick();
        tick();
        check("t3_stall_i1", {16'd0, out_i}, 32'd1);
        out_ready = 1'b1;
        wait_empty("t3_drain", 20);
        check("t3_valid_low", {31'd0, out_valid}, 32'd0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("t3_drop_clr", {31'd0, drop}, 32'd0);

        // 4: write into a full FIFO while popping
        out_ready = 1'b0;
        for (int k = 7; k <= 10; k++) begin
            send(32'(k) << 15, 32'd0, 16'(k), 16'd0, 1);
        end
        tick();
        tick();
        tick();
        send(32'd11 << 15, 32'd0, 16'd11, 16'd0, 1);
        out_ready = 1'b1;
        tick();
        check("t4_no_drop", {31'd0, drop}, 32'd0);
        check("t4_still_valid", {31'd0, out_valid}, 32'd1);
        wait_empty("t4_drain", 20);
        check("t4_no_drop_end", {31'd0, drop}, 32'd0);

        // 5: reset with a populated FIFO and a sample in flight
        out_ready = 1'b0;
        send(32'h4000_0000, 32'd0, 16'h7FFF, 16'd0, 0);
        send(32'd2 << 15, 32'd0, 16'd2, 16'd0, 0);
        send(32'd3 << 15, 32'd0, 16'd3, 16'd0, 0);
        tick();
        tick();
        send(32'd4 << 15, 32'd0, 16'd4, 16'd0, 0);
        check("t5_pre_ovf", {31'd0, ovf}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_ovf", {31'd0, ovf}, 32'd0);
        check("t5_rst_drop", {31'd0, drop}, 32'd0);
        check("t5_rst_out_i", {16'd0, out_i}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        send(32'd5 << 15, 32'd0, 16'd5, 16'd0, 1);
        wait_empty("t5_drain", 10);
        repeat (5) tick();
        check("t5_alone", {31'd0, out_valid}, 32'd0);

        // 6: mixed clipped/clean samples, including one clipping both components
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
`ifdef CMULT_RSF_SATCNT_EN
        check("t6_cnt_clr", {16'd0, sat_count}, 32'd0);
`endif
        send(32'h4000_0000, 32'h0000_0000, 16'h7FFF, 16'h0000, 1);
        send(32'h0000_0000, 32'hBFFF_0000, 16'h0000, 16'h8000, 1);
        send(32'h7FFF_FFFF, 32'h8000_0000, 16'h7FFF, 16'h8000, 1);
        send(32'h0001_8000, 32'hFFFF_8000, 16'h0003, 16'hFFFF, 1);
        wait_empty("t6_drain", 12);
        check("t6_ovf", {31'd0, ovf}, 32'd1);
`ifdef CMULT_RSF_SATCNT_EN
        check("t6_sat_count", {16'd0, sat_count}, 32'd3);
`endif

        // clr_flags in the same cycle as a clipping sample: the set wins
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("clr_ovf", {31'd0, ovf}, 32'd0);
        clr_flags = 1'b1;
        send(32'h4000_0000, 32'd0, 16'h7FFF, 16'd0, 1);
        clr_flags = 1'b0;
        check("clr_vs_set", {31'd0, ovf}, 32'd1);
        wait_empty("final_drain", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
